// File: rtl/mdio_pkg.sv
// Shared MDIO frame constants, FSM state type and header assembly helper.
package mdio_pkg;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam int         HDR_BITS   = 14;
    localparam int         DATA_BITS  = 16;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        TA,
        DATA,
        GAP
    } mdio_state_t;

    // ST, OP, PHYAD, REGAD packed MSB first, ready to be shifted out from bit 13 down.
    function automatic logic [HDR_BITS-1:0] mdio_header(input logic       wr,
                                                        input logic [4:0] phy,
                                                        input logic [4:0] regad);
        return {MDIO_ST, (wr ? MDIO_OP_WR : MDIO_OP_RD), phy, regad};
    endfunction

endpackage

// File: rtl/mdio_master_mdc_gen.sv
// MDC divider: low phase then high phase of CLK_DIV clocks each, with drive/sample/bit-end strobes.
module mdc_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic mdc_o,
    output logic fall_stb_o,
    output logic rise_stb_o,
    output logic end_stb_o
);

    localparam int            CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    // Dropping the enable parks the divider at the start of a low phase.
    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (en_i) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign mdc_o      = phase_q;
    assign fall_stb_o = en_i && !phase_q && (cnt_q == '0);
    assign rise_stb_o = en_i && !phase_q && (cnt_q == CNT_MAX);
    assign end_stb_o  = en_i &&  phase_q && (cnt_q == CNT_MAX);

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: serialises one read or write frame per accepted command.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV      = 25,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clkIn,
    input  logic        rstBIn,
    input  logic        cmdValidIn,
    output logic        cmdReadyOut,
    input  logic        cmdWriteIn,
    input  logic [4:0]  cmdPhyAddrIn,
    input  logic [4:0]  cmdRegAddrIn,
    input  logic [15:0] cmdWrDataIn,
    output logic        rspValidOut,
    output logic [15:0] rspRdDataOut,
    output logic        rspErrOut,
    output logic        mdcOut,
    output logic        mdioOut,
    output logic        mdioOeOut,
    input  logic        mdioIn,
    output mdio_state_t dbgStateOut
);

    // Command handshake: a command transfers on a clock where cmdValidIn && cmdReadyOut.
    localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_LEN - 1);
    localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

    mdio_state_t         state_q, state_d;
    logic [5:0]          bit_q, bit_d;
    logic                wr_q, wr_d;
    logic [4:0]          phy_q, phy_d, reg_q, reg_d;
    logic [15:0]         wdata_q, wdata_d, shift_q, shift_d, rdata_q, rdata_d;
    logic                ta_err_q, ta_err_d, err_q, err_d, rsp_q, rsp_d;
    logic                mdio_q, mdio_d, oe_q, oe_d;
    logic                run, fall_stb, rise_stb, end_stb, mdc;
    logic [HDR_BITS-1:0] hdr;

    assign run = (state_q != IDLE);
    assign hdr = mdio_header(wr_q, phy_q, reg_q);

    mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
        .clk_i      (clkIn),
        .rst_ni     (rstBIn),
        .en_i       (run),
        .mdc_o      (mdc),
        .fall_stb_o (fall_stb),
        .rise_stb_o (rise_stb),
        .end_stb_o  (end_stb)
    );

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        wr_d     = wr_q;
        phy_d    = phy_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        shift_d  = shift_q;
        ta_err_d = ta_err_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        rsp_d    = 1'b0;
        mdio_d   = mdio_q;
        oe_d     = oe_q;

        if (state_q == IDLE) begin
            mdio_d = 1'b1;
            oe_d   = 1'b0;
            if (cmdValidIn) begin
                wr_d    = cmdWriteIn;
                phy_d   = cmdPhyAddrIn;
                reg_d   = cmdRegAddrIn;
                wdata_d = cmdWrDataIn;
                state_d = PRE;
                bit_d   = PRE_LAST;
            end
        end else begin
            if (fall_stb) begin
                case (state_q)
                    PRE:  begin oe_d = 1'b1; mdio_d = 1'b1;             end
                    HDR:  begin oe_d = 1'b1; mdio_d = hdr[bit_q[3:0]]; end
                    // Write turnaround drives 1 then 0; bit_q counts 1 -> 0.
                    TA:   begin oe_d = wr_q; mdio_d = wr_q ? bit_q[0] : 1'b1; end
                    DATA: begin oe_d = wr_q; mdio_d = wr_q ? wdata_q[bit_q[3:0]] : 1'b1; end
                    default: begin oe_d = 1'b0; mdio_d = 1'b1; end
                endcase
            end

            if (rise_stb) begin
                if (state_q == TA && bit_q == 6'd0) begin
                    ta_err_d = mdioIn;
                end
                if (state_q == DATA && !wr_q) begin
                    shift_d = {shift_q[14:0], mdioIn};
                end
            end

            if (end_stb) begin
                if (bit_q != 6'd0) begin
                    bit_d = bit_q - 6'd1;
                end else begin
                    case (state_q)
                        PRE:  begin state_d = HDR;  bit_d = HDR_LAST;  end
                        HDR:  begin state_d = TA;   bit_d = 6'd1;      end
                        TA:   begin state_d = DATA; bit_d = DATA_LAST; end
                        DATA: begin state_d = GAP;  bit_d = 6'd0;      end
                        default: begin
                            state_d = IDLE;
                            bit_d   = 6'd0;
                            rsp_d   = 1'b1;
                            err_d   = !wr_q && ta_err_q;
                            if (!wr_q) begin
                                rdata_d = shift_q;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clkIn or negedge rstBIn) begin
        if (!rstBIn) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            wr_q     <= 1'b0;
            phy_q    <= '0;
            reg_q    <= '0;
            wdata_q  <= '0;
            shift_q  <= '0;
            ta_err_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rsp_q    <= 1'b0;
            mdio_q   <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            wr_q     <= wr_d;
            phy_q    <= phy_d;
            reg_q    <= reg_d;
            wdata_q  <= wdata_d;
            shift_q  <= shift_d;
            ta_err_q <= ta_err_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rsp_q    <= rsp_d;
            mdio_q   <= mdio_d;
            oe_q     <= oe_d;
        end
    end

    assign cmdReadyOut  = (state_q == IDLE);
    assign rspValidOut  = rsp_q;
    assign rspRdDataOut = rdata_q;
    assign rspErrOut    = err_q;
    assign mdcOut       = mdc;
    assign mdioOut      = mdio_q;
    assign mdioOeOut    = oe_q;
    assign dbgStateOut  = state_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: random commands, PHY register-file BFM on MDIO, response and frame scoreboards.
module tb_mdio_master;
    import mdio_pkg::*;

    localparam int         CLK_DIV    = 2;
    localparam int         PRE_LEN    = 32;
    localparam int         FRAME_BITS = PRE_LEN + HDR_BITS + 2 + DATA_BITS + 1;
    localparam int         LATENCY    = FRAME_BITS * 2 * CLK_DIV + 1;
    localparam int         OP_POS     = PRE_LEN + 2;
    localparam int         PHY_POS    = PRE_LEN + 4;
    localparam int         REG_POS    = PRE_LEN + 9;
    localparam int         TA_POS     = PRE_LEN + 14;
    localparam int         DAT_POS    = PRE_LEN + 16;
    localparam int         GAP_POS    = PRE_LEN + 32;
    localparam logic [4:0] BFM_PHY    = 5'h01;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_phy, cmd_reg;
    logic [15:0] cmd_wdata, rsp_rdata;
    logic        rsp_valid, rsp_err;
    logic        mdc, mdio_o, mdio_oe, mdio_i;
    mdio_state_t dbg_state;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [16:0] rsp_exp_q[$];
    int          acc_cyc_q[$];
    logic [26:0] frm_exp_q[$];
    logic [15:0] model_regs[32];
    logic [15:0] model_rd;
    logic [15:0] bfm_regs[32];
    bit          bfm_on;

    int          r = 0;
    logic        bit_v[FRAME_BITS];
    logic        oe_v[FRAME_BITS];
    logic        prev_mdc = 1'b0;
    logic        drv_oe   = 1'b0;
    logic        drv_val  = 1'b1;
    logic        hit      = 1'b0;
    logic [15:0] word;
    int          frames_seen = 0;
    int          rsp_count   = 0;
    bit          last_rsp    = 0;
    logic [16:0] mon_e;
    int          mon_a;

    mdio_master #(.CLK_DIV(CLK_DIV), .PREAMBLE_LEN(PRE_LEN)) dut (
        .clkIn        (clk),
        .rstBIn       (rst_n),
        .cmdValidIn   (cmd_valid),
        .cmdReadyOut  (cmd_ready),
        .cmdWriteIn   (cmd_write),
        .cmdPhyAddrIn (cmd_phy),
        .cmdRegAddrIn (cmd_reg),
        .cmdWrDataIn  (cmd_wdata),
        .rspValidOut  (rsp_valid),
        .rspRdDataOut (rsp_rdata),
        .rspErrOut    (rsp_err),
        .mdcOut       (mdc),
        .mdioOut      (mdio_o),
        .mdioOeOut    (mdio_oe),
        .mdioIn       (mdio_i),
        .dbgStateOut  (dbg_state)
    );

    // Shared line with pull-up: master wins when enabled, else PHY, else 1.
    assign mdio_i = mdio_oe ? mdio_o : (drv_oe ? drv_val : 1'b1);

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, want finish earlier");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic wr, input logic [4:0] phy, input logic [4:0] ra,
                         input logic [15:0] d, input bit track);
        bit          got;
        logic [16:0] exp_rsp;
        got = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_phy   = phy;
        cmd_reg   = ra;
        cmd_wdata = d;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1;
                if (track) begin
                    if (wr) begin
                        exp_rsp = {1'b0, model_rd};
                        if (phy == BFM_PHY && bfm_on) model_regs[ra] = d;
                    end else if (phy == BFM_PHY && bfm_on) begin
                        model_rd = model_regs[ra];
                        exp_rsp  = {1'b0, model_rd};
                    end else begin
                        model_rd = 16'hFFFF;
                        exp_rsp  = {1'b1, model_rd};
                    end
                    rsp_exp_q.push_back(exp_rsp);
                    acc_cyc_q.push_back(cyc);
                    frm_exp_q.push_back({wr, phy, ra, d});
                end
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_phy   = 5'($urandom);
        cmd_reg   = 5'($urandom);
        cmd_wdata = 16'($urandom);
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: ready never seen, want accept");
        end
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (rsp_exp_q.size() != 0 && i < 1000) begin
            @(negedge clk);
            i++;
        end
        if (rsp_exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: %0d outstanding, want 0", rsp_exp_q.size());
            rsp_exp_q.delete();
            acc_cyc_q.delete();
            frm_exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rsp();
        bit seen;
        seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL rsp_wait_timeout: no rspValid, want one");
        end
    endtask

    // ---------------- PHY BFM ----------------
    function automatic logic [15:0] field(input int pos, input int n);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[14:0], bit_v[pos + i]};
        return v;
    endfunction

    function automatic int count_oe(input int pos, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) if (oe_v[pos + i]) c++;
        return c;
    endfunction

    task automatic frame_check();
        logic [26:0] e;
        logic [15:0] tmp;
        logic [4:0]  phy_got, reg_got;
        logic [1:0]  op_got;
        int          pre_ok;
        frames_seen++;
        tmp     = field(OP_POS, 2);
        op_got  = tmp[1:0];
        tmp     = field(PHY_POS, 5);
        phy_got = tmp[4:0];
        tmp     = field(REG_POS, 5);
        reg_got = tmp[4:0];
        if (op_got == MDIO_OP_WR && phy_got == BFM_PHY && bfm_on)
            bfm_regs[reg_got] = field(DAT_POS, 16);
        if (frm_exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected: got a frame, want none");
            return;
        end
        e = frm_exp_q.pop_front();
        pre_ok = 0;
        for (int i = 0; i < PRE_LEN; i++) if (bit_v[i] && oe_v[i]) pre_ok++;
        check("frame_preamble", 32'(pre_ok), 32'(PRE_LEN));
        check("frame_st", 32'(field(PRE_LEN, 2)), 32'(MDIO_ST));
        check("frame_hdr_oe", 32'(count_oe(PRE_LEN, HDR_BITS)), 32'(HDR_BITS));
        check("frame_op", 32'(op_got), 32'(e[26] ? MDIO_OP_WR : MDIO_OP_RD));
        check("frame_phy", 32'(phy_got), 32'(e[25:21]));
        check("frame_reg", 32'(reg_got), 32'(e[20:16]));
        if (e[26]) begin
            check("frame_ta", 32'(field(TA_POS, 2)), 32'd2);
            check("frame_wr_oe", 32'(count_oe(TA_POS, 18)), 32'd18);
            check("frame_wdata", 32'(field(DAT_POS, 16)), 32'(e[15:0]));
        end else begin
            check("frame_rd_oe", 32'(count_oe(TA_POS, 18)), 32'd0);
        end
        check("frame_gap_oe", 32'(oe_v[GAP_POS]), 32'd0);
    endtask

    // One step per MDC rising edge: record the master's bit, then set up the PHY's next bit.
    always @(negedge clk) begin
        if (!rst_n || rsp_valid) begin
            r      = 0;
            drv_oe = 1'b0;
            hit    = 1'b0;
        end else if (mdc && !prev_mdc) begin
            if (r < FRAME_BITS) begin
                bit_v[r] = mdio_o;
                oe_v[r]  = mdio_oe;
            end
            if (r == REG_POS + 4) begin
                logic [15:0] t;
                t      = field(PHY_POS, 5);
                hit    = (field(OP_POS, 2) == 16'(MDIO_OP_RD)) && (t[4:0] == BFM_PHY) && bfm_on;
                t      = field(REG_POS, 5);
                word   = bfm_regs[t[4:0]];
                drv_oe = 1'b0;
            end else if (hit && r == TA_POS) begin
                drv_oe  = 1'b1;
                drv_val = 1'b0;
            end else if (hit && r >= TA_POS + 1 && r <= TA_POS + 16) begin
                drv_oe  = 1'b1;
                drv_val = word[15 - (r - TA_POS - 1)];
            end else if (r == TA_POS + 17) begin
                drv_oe = 1'b0;
            end
            if (r == GAP_POS) frame_check();
            r++;
        end
        prev_mdc = mdc;
    end

    // ---------------- response monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            last_rsp = 0;
        end else if (last_rsp) begin
            check("rsp_pulse", 32'(rsp_valid), 32'd0);
            last_rsp = 0;
        end else if (rsp_valid) begin
            rsp_count++;
            last_rsp = 1;
            if (rsp_exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got rspValid, want none");
            end else begin
                mon_e = rsp_exp_q.pop_front();
                mon_a = acc_cyc_q.pop_front();
                check("rsp_err", 32'(rsp_err), 32'(mon_e[16]));
                check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e[15:0]));
                check("rsp_latency", 32'(cyc - mon_a), 32'(LATENCY));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          flag;
        int          f0, n0;
        logic        w;
        logic [4:0]  p, ra;
        logic [15:0] v;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_phy   = '0;
        cmd_reg   = '0;
        cmd_wdata = '0;
        bfm_on    = 1;
        model_rd  = '0;
        for (int i = 0; i < 32; i++) begin
            v             = 16'($urandom);
            model_regs[i] = v;
            bfm_regs[i]   = v;
        end
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state and idle MDC
        @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_mdc", 32'(mdc), 32'd0);
        check("rst_mdio", 32'(mdio_o), 32'd1);
        check("rst_oe", 32'(mdio_oe), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        flag = 0;
        repeat (20) begin
            @(negedge clk);
            if (mdc) flag = 1;
        end
        check("idle_mdc", 32'(flag), 32'd0);

        // directed write, read, read without PHY
        issue(1'b1, 5'h01, 5'h00, 16'h1140, 1);
        wait_done();
        model_regs[2] = 16'h0141;
        bfm_regs[2]   = 16'h0141;
        issue(1'b0, 5'h01, 5'h02, 16'h0000, 1);
        wait_done();
        bfm_on = 0;
        issue(1'b0, 5'h01, 5'h02, 16'h0000, 1);
        wait_done();
        bfm_on = 1;

        // request while busy is dropped; back-to-back after the response
        f0 = frames_seen;
        issue(1'b1, 5'h01, 5'h04, 16'h01E1, 1);
        repeat (10) @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_phy   = 5'h01;
        cmd_reg   = 5'h1F;
        flag = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_ready) flag = 1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("busy_ready", 32'(flag), 32'd0);
        wait_rsp();
        issue(1'b0, 5'h01, 5'h04, 16'h0000, 1);
        wait_done();
        check("frame_count", 32'(frames_seen - f0), 32'd2);

        // reset during preamble of a write
        f0 = frames_seen;
        n0 = rsp_count;
        issue(1'b1, 5'h01, 5'h09, 16'hBEEF, 0);
        flag = 0;
        for (int i = 0; i < 400 && !flag; i++) begin
            @(posedge clk);
            if (r >= 11) flag = 1;
        end
        check("abort_reach", 32'(flag), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_oe", 32'(mdio_oe), 32'd0);
        check("abort_mdc", 32'(mdc), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        model_rd = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_count - n0), 32'd0);
        check("abort_no_frame", 32'(frames_seen - f0), 32'd0);
        issue(1'b1, 5'h01, 5'h09, 16'h1234, 1);
        wait_done();
        issue(1'b0, 5'h01, 5'h09, 16'h0000, 1);
        wait_done();

        // random commands, mixed spacing
        for (int n = 0; n < 12; n++) begin
            bfm_on = ($urandom_range(0, 4) != 0);
            w      = 1'($urandom_range(0, 1));
            p      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : BFM_PHY;
            ra     = 5'($urandom_range(0, 31));
            v      = 16'($urandom);
            issue(w, p, ra, v, 1);
            if ($urandom_range(0, 1) == 0) wait_done();
            else wait_rsp();
        end
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
